// File: rtl/otter_mem_pkg.sv
// Shared types and constants for the OTTER memory bridge.
package otter_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      INST = 2'b01,
      DATA = 2'b10,
      RESP = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10,
      RSVD = 2'b11
   } size_e;

   localparam logic [31:0] NOP = 32'h0000_0013;

   // Misaligned halves/words and the reserved size never reach the bus.
   function automatic logic bad_access(input size_e size, input logic [1:0] addr);
      logic bad;
      case (size)
         BYTE:    bad = 1'b0;
         HALF:    bad = addr[0];
         WORD:    bad = (addr != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/otter_mem_bridge_load_align.sv
// Combinational load extraction: lane select, truncate, sign/zero extend.
module load_align
   import otter_mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [1:0]  SIZE,
   input  logic        SIGN,
   output logic [31:0] data
);

   logic [31:0] w_shifted;

   always_comb begin
      w_shifted = rdata >> {addr, 3'b000};
      // SIGN=0 requests sign extension, SIGN=1 zero extension.
      case (size_e'(SIZE))
         BYTE:    data = {{24{~SIGN & w_shifted[7]}},  w_shifted[7:0]};
         HALF:    data = {{16{~SIGN & w_shifted[15]}}, w_shifted[15:0]};
         default: data = w_shifted;
      endcase
   end

endmodule

// File: rtl/otter_mem_bridge.sv
// Arbitrates OTTER fetch and data requests onto one single-port bus with
// data priority, lane steering, load alignment, misalignment and timeout handling.
module otter_mem_bridge
   import otter_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        RST_N,
   input  logic        memRDEN1,
   input  logic [31:0] ADDR1,
   input  logic        memRDEN2,
   input  logic        memWE2,
   input  logic [31:0] ADDR2,
   input  logic [31:0] DIN2,
   input  logic [1:0]  SIZE,
   input  logic        SIGN,
   output logic [31:0] DOUT1,
   output logic [31:0] DOUT2,
   output logic        stall,
   output logic        err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_e        r_state;
   state_e        w_next;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   size_e         r_size;
   logic          r_sign;
   logic          r_we;
   logic [CW-1:0] r_wait;
   logic [31:0]   r_dout1;
   logic [31:0]   r_dout2;
   logic          r_err;

   logic          w_data_req;
   logic          w_bad;
   logic          w_timeout;
   logic [31:0]   w_load_data;

   assign w_data_req = memRDEN2 | memWE2;
   assign w_bad      = bad_access(size_e'(SIZE), ADDR2[1:0]);
   assign w_timeout  = (r_wait == CW'(TIMEOUT - 1)) & ~bus_ack;

   load_align u_load_align (
      .rdata (bus_rdata),
      .addr  (r_addr[1:0]),
      .SIZE  (r_size),
      .SIGN  (r_sign),
      .data  (w_load_data)
   );

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_data_req)    w_next = w_bad ? RESP : DATA;
            else if (memRDEN1) w_next = INST;
         end
         INST, DATA: begin
            if (bus_ack || w_timeout) w_next = RESP;
         end
         default: w_next = IDLE;
      endcase
   end

   // Bus side is driven purely from latched request fields and the state.
   always_comb begin
      stall     = 1'b0;
      bus_req   = 1'b0;
      bus_we    = 1'b0;
      bus_be    = '0;
      bus_addr  = {r_addr[31:2], 2'b00};
      case (r_size)
         BYTE:    bus_wdata = {4{r_wdata[7:0]}};
         HALF:    bus_wdata = {2{r_wdata[15:0]}};
         default: bus_wdata = r_wdata;
      endcase
      case (r_state)
         IDLE: stall = w_data_req | memRDEN1;
         INST: begin
            stall   = 1'b1;
            bus_req = 1'b1;
            bus_be  = 4'b1111;
         end
         DATA: begin
            stall   = 1'b1;
            bus_req = 1'b1;
            bus_we  = r_we;
            case (r_size)
               BYTE:    bus_be = 4'b0001 << r_addr[1:0];
               HALF:    bus_be = 4'b0011 << r_addr[1:0];
               default: bus_be = 4'b1111;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_size  <= BYTE;
         r_sign  <= 1'b0;
         r_we    <= 1'b0;
         r_wait  <= '0;
         r_dout1 <= '0;
         r_dout2 <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_data_req) begin
                  r_addr  <= ADDR2;
                  r_wdata <= DIN2;
                  r_size  <= size_e'(SIZE);
                  r_sign  <= SIGN;
                  r_we    <= memWE2;
                  r_wait  <= '0;
                  if (w_bad) begin
                     r_err <= 1'b1;
                     if (!memWE2) r_dout2 <= '0;
                  end
               end else if (memRDEN1) begin
                  r_addr <= ADDR1;
                  r_size <= WORD;
                  r_sign <= 1'b0;
                  r_we   <= 1'b0;
                  r_wait <= '0;
               end
            end
            INST: begin
               if (bus_ack) begin
                  r_dout1 <= bus_rdata;
               end else if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_dout1 <= NOP;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            DATA: begin
               if (bus_ack) begin
                  if (!r_we) r_dout2 <= w_load_data;
               end else if (w_timeout) begin
                  r_err <= 1'b1;
                  if (!r_we) r_dout2 <= '0;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign DOUT1 = r_dout1;
   assign DOUT2 = r_dout2;
   assign err   = r_err;

endmodule
